// File: rtl/pipe_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline stall/flush control, trap entry CSR sequencing and mret.
// Revision : 1.0
// =============================================================================
module pipe_ctrl #(
   parameter int MTVEC_VECTORED = 0,
   parameter int IRQ_CAUSE      = 11
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stallreq_if_i,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        stallreq_mem_i,
   input  logic        branch_redirect_i,
   input  logic [31:0] branch_target_i,
   input  logic [31:0] exception_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] mem_addr_i,
   input  logic        irq_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic        redirect_o,
   output logic [31:0] new_pc_o,
   output logic        csr_we_o,
   output logic [31:0] csr_waddr_o,
   output logic [31:0] csr_wdata_o
);

   localparam logic [31:0] C_ADDR_MSTATUS = 32'h0000_0300;
   localparam logic [31:0] C_ADDR_MEPC    = 32'h0000_0341;
   localparam logic [31:0] C_ADDR_MCAUSE  = 32'h0000_0342;
   localparam logic [31:0] C_ADDR_MTVAL   = 32'h0000_0343;
   localparam logic [31:0] C_IRQ_MCAUSE   = 32'h8000_0000 | 32'(IRQ_CAUSE);
   localparam logic [31:0] C_IRQ_OFFSET   = 32'(4 * IRQ_CAUSE);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      W_MEPC    = 3'd1,
      W_MCAUSE  = 3'd2,
      W_MTVAL   = 3'd3,
      W_MSTATUS = 3'd4,
      MRET_ST   = 3'd5,
      JUMP      = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_cause;
   logic [31:0] r_tval;
   logic        r_is_irq;
   logic        r_is_mret;

   logic        w_exc;
   logic        w_mret;
   logic        w_irq;
   logic        w_trap;
   logic [31:0] w_cause;
   logic [31:0] w_tval;
   logic        w_vec_en;
   logic [31:0] w_base;
   logic [31:0] w_jump_tgt;
   logic        w_unused;

   generate
      if (MTVEC_VECTORED == 1) begin : g_vectored
         assign w_vec_en = 1'b1;
      end else begin : g_direct
         assign w_vec_en = 1'b0;
      end
   endgenerate

   assign w_unused = ^exception_i[31:6];

   // Trap event decode, only meaningful while IDLE
   always_comb begin
      w_exc   = |exception_i[4:0];
      w_mret  = ~w_exc & exception_i[5];
      w_irq   = ~w_exc & ~exception_i[5] & irq_i & mstatus_i[3] & (pc_i != 32'd0);
      w_trap  = w_exc | w_mret | w_irq;
      w_cause = 32'd0;
      w_tval  = 32'd0;
      if (exception_i[2]) begin
         w_cause = 32'd2;
         w_tval  = inst_i;
      end else if (exception_i[1]) begin
         w_cause = 32'd3;
      end else if (exception_i[0]) begin
         w_cause = 32'd11;
      end else if (exception_i[3]) begin
         w_cause = 32'd4;
         w_tval  = mem_addr_i;
      end else if (exception_i[4]) begin
         w_cause = 32'd6;
         w_tval  = mem_addr_i;
      end else if (w_irq) begin
         w_cause = C_IRQ_MCAUSE;
      end
   end

   always_comb begin
      w_base = {mtvec_i[31:2], 2'b00};
      if (r_is_mret) begin
         w_jump_tgt = mepc_i;
      end else if (r_is_irq && w_vec_en && (mtvec_i[1:0] == 2'b01)) begin
         w_jump_tgt = w_base + C_IRQ_OFFSET;
      end else begin
         w_jump_tgt = w_base;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_pc      <= 32'd0;
         r_cause   <= 32'd0;
         r_tval    <= 32'd0;
         r_is_irq  <= 1'b0;
         r_is_mret <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_trap) begin
            r_pc      <= pc_i;
            r_cause   <= w_cause;
            r_tval    <= w_tval;
            r_is_irq  <= w_irq;
            r_is_mret <= w_mret;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      stall_o     = 6'b000000;
      flush_o     = 1'b0;
      redirect_o  = 1'b0;
      new_pc_o    = 32'd0;
      csr_we_o    = 1'b0;
      csr_waddr_o = 32'd0;
      csr_wdata_o = 32'd0;
      case (r_state)
         IDLE: begin
            if (w_trap) begin
               flush_o     = 1'b1;
               w_state_nxt = w_mret ? MRET_ST : W_MEPC;
            end else begin
               if (stallreq_mem_i)      stall_o = 6'b011111;
               else if (stallreq_ex_i)  stall_o = 6'b001111;
               else if (stallreq_id_i)  stall_o = 6'b000111;
               else if (stallreq_if_i)  stall_o = 6'b000011;
               if (branch_redirect_i) begin
                  redirect_o = 1'b1;
                  new_pc_o   = branch_target_i;
               end
            end
         end
         W_MEPC: begin
            stall_o     = 6'b111111;
            csr_we_o    = 1'b1;
            csr_waddr_o = C_ADDR_MEPC;
            csr_wdata_o = r_pc;
            w_state_nxt = W_MCAUSE;
         end
         W_MCAUSE: begin
            stall_o     = 6'b111111;
            csr_we_o    = 1'b1;
            csr_waddr_o = C_ADDR_MCAUSE;
            csr_wdata_o = r_cause;
            w_state_nxt = W_MTVAL;
         end
         W_MTVAL: begin
            stall_o     = 6'b111111;
            csr_we_o    = 1'b1;
            csr_waddr_o = C_ADDR_MTVAL;
            csr_wdata_o = r_tval;
            w_state_nxt = W_MSTATUS;
         end
         W_MSTATUS: begin
            // MPIE <= MIE, MIE <= 0
            stall_o     = 6'b111111;
            csr_we_o    = 1'b1;
            csr_waddr_o = C_ADDR_MSTATUS;
            csr_wdata_o = {mstatus_i[31:8], mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
            w_state_nxt = JUMP;
         end
         MRET_ST: begin
            // MIE <= MPIE, MPIE <= 1
            stall_o     = 6'b111111;
            csr_we_o    = 1'b1;
            csr_waddr_o = C_ADDR_MSTATUS;
            csr_wdata_o = {mstatus_i[31:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
            w_state_nxt = JUMP;
         end
         JUMP: begin
            redirect_o  = 1'b1;
            new_pc_o    = w_jump_tgt;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // Reset silences every output so an aborted sequence issues nothing further
      if (rst_i) begin
         stall_o     = 6'b000000;
         flush_o     = 1'b0;
         redirect_o  = 1'b0;
         new_pc_o    = 32'd0;
         csr_we_o    = 1'b0;
         csr_waddr_o = 32'd0;
         csr_wdata_o = 32'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Randomized self-checking bench for pipe_ctrl against a trace model.
// Revision : 1.0
// =============================================================================
module tb_pipe_ctrl;

   localparam int IRQ_CAUSE = 11;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
   logic        branch_redirect_i;
   logic [31:0] branch_target_i;
   logic [31:0] exception_i;
   logic [31:0] pc_i, inst_i, mem_addr_i;
   logic        irq_i;
   logic [31:0] mstatus_i, mtvec_i, mepc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic        redirect_o;
   logic [31:0] new_pc_o;
   logic        csr_we_o;
   logic [31:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;

   always #5 clk_i = ~clk_i;

   pipe_ctrl #(
      .MTVEC_VECTORED (1),
      .IRQ_CAUSE      (IRQ_CAUSE)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .stallreq_if_i     (stallreq_if_i),
      .stallreq_id_i     (stallreq_id_i),
      .stallreq_ex_i     (stallreq_ex_i),
      .stallreq_mem_i    (stallreq_mem_i),
      .branch_redirect_i (branch_redirect_i),
      .branch_target_i   (branch_target_i),
      .exception_i       (exception_i),
      .pc_i              (pc_i),
      .inst_i            (inst_i),
      .mem_addr_i        (mem_addr_i),
      .irq_i             (irq_i),
      .mstatus_i         (mstatus_i),
      .mtvec_i           (mtvec_i),
      .mepc_i            (mepc_i),
      .stall_o           (stall_o),
      .flush_o           (flush_o),
      .redirect_o        (redirect_o),
      .new_pc_o          (new_pc_o),
      .csr_we_o          (csr_we_o),
      .csr_waddr_o       (csr_waddr_o),
      .csr_wdata_o       (csr_wdata_o)
   );

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic        redir;
      logic [31:0] pc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   // Expected per-cycle outputs of a trap sequence still to be played out
   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t csr_cycle(input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      e       = '0;
      e.stall = 6'h3F;
      e.we    = 1'b1;
      e.addr  = addr;
      e.data  = data;
      return e;
   endfunction

   // Script the whole trap sequence from the accept-cycle inputs
   task automatic expect_trap();
      logic [31:0] cause, tval, base, tgt, ms;
      bit          is_irq, is_mret;
      exp_t        e;
      cause   = 0;
      tval    = 0;
      is_irq  = 0;
      is_mret = 0;
      base    = mtvec_i & 32'hFFFF_FFFC;
      if (exception_i[2])      begin cause = 2;  tval = inst_i;     end
      else if (exception_i[1]) cause = 3;
      else if (exception_i[0]) cause = 11;
      else if (exception_i[3]) begin cause = 4;  tval = mem_addr_i; end
      else if (exception_i[4]) begin cause = 6;  tval = mem_addr_i; end
      else if (exception_i[5]) is_mret = 1;
      else begin
         is_irq = 1;
         cause  = 32'h8000_0000 + IRQ_CAUSE;
      end
      if (is_mret) begin
         ms = (mstatus_i & ~32'h0000_0008) | 32'h80 | (mstatus_i[7] ? 32'h8 : 32'h0);
         q.push_back(csr_cycle(32'h300, ms));
         tgt = mepc_i;
      end else begin
         ms = (mstatus_i & ~32'h0000_0088) | (mstatus_i[3] ? 32'h80 : 32'h0);
         q.push_back(csr_cycle(32'h341, pc_i));
         q.push_back(csr_cycle(32'h342, cause));
         q.push_back(csr_cycle(32'h343, tval));
         q.push_back(csr_cycle(32'h300, ms));
         tgt = (is_irq && mtvec_i[1:0] == 2'b01) ? base + 4 * IRQ_CAUSE : base;
      end
      e       = '0;
      e.redir = 1'b1;
      e.pc    = tgt;
      q.push_back(e);
   endtask

   // Called just after a falling edge with inputs already applied
   task automatic step();
      exp_t e;
      bit   accept;
      bit   trap;
      e      = '0;
      accept = 0;
      trap   = (exception_i[5:0] != 6'd0) || (irq_i && mstatus_i[3] && pc_i != 32'd0);
      if (rst_i) begin
         q.delete();
      end else if (q.size() > 0) begin
         e = q.pop_front();
      end else if (trap) begin
         e.flush = 1'b1;
         accept  = 1;
      end else begin
         e.stall = stallreq_mem_i ? 6'h1F : stallreq_ex_i ? 6'h0F :
                   stallreq_id_i  ? 6'h07 : stallreq_if_i ? 6'h03 : 6'h00;
         e.redir = branch_redirect_i;
         e.pc    = branch_target_i;
      end
      #1;
      check("stall", {26'd0, stall_o}, {26'd0, e.stall});
      check("flush", {31'd0, flush_o}, {31'd0, e.flush});
      check("redirect", {31'd0, redirect_o}, {31'd0, e.redir});
      if (e.redir) check("new_pc", new_pc_o, e.pc);
      check("csr_we", {31'd0, csr_we_o}, {31'd0, e.we});
      check("csr_waddr", csr_waddr_o, e.addr);
      check("csr_wdata", csr_wdata_o, e.data);
      if (accept) expect_trap();
      @(negedge clk_i);
   endtask

   task automatic quiet();
      rst_i             = 0;
      stallreq_if_i     = 0;
      stallreq_id_i     = 0;
      stallreq_ex_i     = 0;
      stallreq_mem_i    = 0;
      branch_redirect_i = 0;
      branch_target_i   = 32'h0;
      exception_i       = 32'h0;
      irq_i             = 0;
      pc_i              = 32'h0;
      inst_i            = 32'h0;
      mem_addr_i        = 32'h0;
   endtask

   initial begin
      quiet();
      mstatus_i = 32'h0;
      mtvec_i   = 32'h0;
      mepc_i    = 32'h0;
      rst_i     = 1;
      step();
      step();
      rst_i = 0;
      step();

      // Stall priority and branch redirect
      stallreq_ex_i = 1; stallreq_if_i = 1;
      step();
      branch_redirect_i = 1; branch_target_i = 32'h0000_4440; stallreq_mem_i = 1;
      step();
      quiet();

      // Illegal instruction trap
      exception_i = 32'h4; inst_i = 32'hFFFF_FFFF; pc_i = 32'h100;
      mtvec_i = 32'h200; mstatus_i = 32'h0000_1808;
      step();
      quiet();
      repeat (6) step();

      // Ecall together with a branch redirect
      exception_i = 32'h1; branch_redirect_i = 1; branch_target_i = 32'h0000_0BAD;
      pc_i = 32'h0000_0444; mtvec_i = 32'h0000_0302;
      step();
      quiet();
      repeat (6) step();

      // mret
      exception_i = 32'h20; mepc_i = 32'h80; mstatus_i = 32'h80; pc_i = 32'h24;
      step();
      quiet();
      repeat (3) step();

      // Vectored interrupt
      irq_i = 1; mstatus_i = 32'h8; mtvec_i = 32'h201; pc_i = 32'h0000_0500;
      step();
      quiet();
      repeat (6) step();

      // Reset during the mcause write
      exception_i = 32'h8; mem_addr_i = 32'h0000_0013; pc_i = 32'h0000_0600;
      step();
      quiet();
      step();
      rst_i = 1;
      step();
      rst_i = 0;
      repeat (3) step();

      for (int i = 0; i < 1500; i++) begin
         rst_i             = ($urandom_range(0, 59) == 0);
         stallreq_if_i     = ($urandom_range(0, 2) == 0);
         stallreq_id_i     = ($urandom_range(0, 2) == 0);
         stallreq_ex_i     = ($urandom_range(0, 3) == 0);
         stallreq_mem_i    = ($urandom_range(0, 4) == 0);
         branch_redirect_i = ($urandom_range(0, 3) == 0);
         branch_target_i   = $urandom;
         case ($urandom_range(0, 11))
            0:       exception_i = $urandom;
            1, 2:    exception_i = (32'h1 << $urandom_range(0, 5)) | ($urandom & 32'hFFFF_FFC0);
            default: exception_i = $urandom & 32'hFFFF_FFC0;
         endcase
         irq_i      = ($urandom_range(0, 7) == 0);
         pc_i       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         inst_i     = $urandom;
         mem_addr_i = $urandom;
         if (q.size() == 0) begin
            mstatus_i = $urandom;
            mtvec_i   = $urandom;
            mepc_i    = $urandom;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MTVEC_VECTORED, default 0, meaning 1 enables vectored interrupt entry (base + 4*cause).
REQ-002 Parameter: IRQ_CAUSE, default 11, meaning interrupt cause code (machine external).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i  in  1 each  stage stall requests.
REQ-006 branch_redirect_i  in  1; branch_target_i  in  32  taken-branch redirect from EX.
REQ-007 exception_i  in  32  MEM-stage flags: bit0 ecall, bit1 ebreak, bit2 illegal, bit3 load-misaligned, bit4 store-misaligned, bit5 mret; other bits ignored.
REQ-008 pc_i, inst_i, mem_addr_i  in  32 each  MEM-stage PC, instruction, data address.
REQ-009 irq_i  in  1  level interrupt request; mstatus_i, mtvec_i, mepc_i  in  32 each  current CSR values.
REQ-010 stall_o  out  6  bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
REQ-011 flush_o  out  1  clears all stage registers to NOP.
REQ-012 redirect_o  out  1; new_pc_o  out  32  fetch redirect, valid for exactly the cycle redirect_o=1.
REQ-013 csr_we_o  out  1; csr_waddr_o  out  32; csr_wdata_o  out  32  trap CSR write port.

Function
REQ-014 FSM states: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, MRET_ST, JUMP; all outputs registered or decoded from state plus IDLE-cycle inputs.
REQ-015 IDLE, no trap event: stall_o = 6'b011111 if stallreq_mem_i, else 6'b001111 if stallreq_ex_i, else 6'b000111 if stallreq_id_i, else 6'b000011 if stallreq_if_i, else 0.
REQ-016 IDLE, branch_redirect_i=1, no trap event: redirect_o=1, new_pc_o=branch_target_i same cycle; stall_o per REQ-015.
REQ-017 Trap event = any of exception_i[4:0], else exception_i[5] (mret), else irq_i && mstatus_i[3] && pc_i!=0.
REQ-018 Exception priority: illegal > ebreak > ecall > load-misaligned > store-misaligned > mret > interrupt; trap event overrides branch redirect and stall requests.
REQ-019 Trap-accept cycle (IDLE): flush_o=1, stall_o=0, redirect_o=0; latch pc_i, cause, tval; next state W_MEPC (exception/irq) or MRET_ST (mret).
REQ-020 mcause: illegal 2, ebreak 3, load-misaligned 4, store-misaligned 6, ecall 11, interrupt 32'h8000_0000 | IRQ_CAUSE.
REQ-021 mtval: misaligned -> mem_addr_i; illegal -> inst_i; others 0.
REQ-022 W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS: one cycle each, csr_we_o=1, stall_o=6'b111111, addresses 0x341, 0x342, 0x343, 0x300.
REQ-023 W_MSTATUS data: mstatus_i with MPIE(bit7)=MIE(bit3), MIE=0, other bits unchanged.
REQ-024 MRET_ST: csr_we_o=1, addr 0x300, data mstatus_i with MIE=MPIE, MPIE=1; stall_o=6'b111111.
REQ-025 JUMP: redirect_o=1, stall_o=0, csr_we_o=0; then IDLE.
REQ-026 JUMP target: mret -> mepc_i; exception -> {mtvec_i[31:2],2'b00}; interrupt -> base + 4*IRQ_CAUSE if MTVEC_VECTORED=1 and mtvec_i[1:0]=1, else base.
REQ-027 Non-IDLE states ignore stall requests, branch_redirect_i, exception_i, irq_i.
REQ-028 csr_waddr_o, csr_wdata_o = 0 whenever csr_we_o=0.

Reset
REQ-029 rst_i=1: state IDLE, latched pc/cause/tval cleared, all outputs 0 in the following cycle.
REQ-030 rst_i asserted mid-sequence: sequence aborted, no further CSR write, no redirect.

Verification
REQ-031 stallreq_ex_i=1 and stallreq_if_i=1 in IDLE -> stall_o=6'b001111, flush_o=0.
REQ-032 exception_i=32'h4, inst_i=32'hFFFF_FFFF, pc_i=32'h100, mtvec_i=32'h200 -> flush 1 cycle; writes 0x341<-0x100, 0x342<-2, 0x343<-0xFFFF_FFFF, 0x300 MIE=0; JUMP new_pc_o=0x200; 6 cycles total.
REQ-033 exception_i=32'h1 with branch_redirect_i=1 same cycle -> no branch redirect; mcause 11; final new_pc_o=mtvec base.
REQ-034 exception_i=32'h20, mepc_i=32'h80, mstatus_i=32'h80 -> flush; MRET_ST writes 0x300<-0x88; JUMP new_pc_o=0x80.
REQ-035 irq_i=1, mstatus_i[3]=1, mtvec_i=32'h201, MTVEC_VECTORED=1 -> mcause 32'h8000_000B; new_pc_o=0x22C.
REQ-036 rst_i asserted during W_MCAUSE -> next cycle all outputs 0, state IDLE, no JUMP.
